// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for a small MIPS-like datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). All
// control outputs are decoded from the registered state and the latched
// instruction word. Every control is held low while reset is asserted.
// A retired-instruction counter advances on each PC update.

module mc_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        Instr,
    input  logic               dm_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic [1:0]         EXTOp,
    output logic [2:0]         ALUOp,
    output logic               if_beq,
    output logic               if_jal,
    output logic               if_jr,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    // Sequencer states. Codes 5-7 are unused and recover to FETCH.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Decoded instruction class. Anything unsupported is a NOP.
    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_ADDU = 4'd1,
        C_SUBU = 4'd2,
        C_JR   = 4'd3,
        C_ORI  = 4'd4,
        C_LUI  = 4'd5,
        C_LW   = 4'd6,
        C_SW   = 4'd7,
        C_BEQ  = 4'd8,
        C_JAL  = 4'd9
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Map an instruction word onto its class.
    function automatic instr_class_t decode_instr(input logic [31:0] instr);
        instr_class_t cls;
        cls = C_NOP;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADDU: cls = C_ADDU;
                    FN_SUBU: cls = C_SUBU;
                    FN_JR:   cls = C_JR;
                    default: cls = C_NOP;
                endcase
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_JAL:  cls = C_JAL;
            default: cls = C_NOP;
        endcase
        return cls;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [COUNT_W-1:0] r_count;
    instr_class_t       w_class;

    // Operand/ALU selection established in EXEC and held through MEM/WB.
    logic [2:0]         w_ex_alu_op;
    logic               w_ex_alu_src;
    logic [1:0]         w_ex_ext_op;

    // Ungated controls from the sequencer.
    logic               w_pc_write;
    logic               w_ir_write;
    logic               w_reg_dst;
    logic               w_reg_write;
    logic               w_alu_src;
    logic               w_mem_write;
    logic               w_mem_to_reg;
    logic [1:0]         w_ext_op;
    logic [2:0]         w_alu_op;
    logic               w_if_beq;
    logic               w_if_jal;
    logic               w_if_jr;

    // Register fields are consumed by the datapath, not by the controller.
    logic               w_unused_fields;

    assign w_class         = decode_instr(Instr);
    assign w_unused_fields = ^Instr[25:6];

    // Per-instruction ALU operation, B-operand source and immediate extension.
    always_comb begin
        w_ex_alu_op  = ALU_ADD;
        w_ex_alu_src = 1'b0;
        w_ex_ext_op  = EXT_ZERO;
        case (w_class)
            C_ADDU: begin
                w_ex_alu_op  = ALU_ADD;
            end
            C_SUBU: begin
                w_ex_alu_op  = ALU_SUB;
            end
            C_ORI: begin
                w_ex_alu_op  = ALU_OR;
                w_ex_alu_src = 1'b1;
                w_ex_ext_op  = EXT_ZERO;
            end
            C_LUI: begin
                w_ex_alu_op  = ALU_ADD;
                w_ex_alu_src = 1'b1;
                w_ex_ext_op  = EXT_LUI;
            end
            C_LW, C_SW: begin
                w_ex_alu_op  = ALU_ADD;
                w_ex_alu_src = 1'b1;
                w_ex_ext_op  = EXT_SIGN;
            end
            C_BEQ: begin
                w_ex_alu_op  = ALU_SUB;
                w_ex_ext_op  = EXT_SIGN;
            end
            default: begin
                w_ex_alu_op  = ALU_ADD;
                w_ex_alu_src = 1'b0;
                w_ex_ext_op  = EXT_ZERO;
            end
        endcase
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_next_state = S_FETCH;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_ext_op     = EXT_ZERO;
        w_alu_op     = ALU_ADD;
        w_if_beq     = 1'b0;
        w_if_jal     = 1'b0;
        w_if_jr      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // A NOP retires here by stepping the PC to PC+4.
                if (w_class == C_NOP) begin
                    w_pc_write   = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_op  = w_ex_alu_op;
                w_alu_src = w_ex_alu_src;
                w_ext_op  = w_ex_ext_op;
                case (w_class)
                    C_BEQ: begin
                        w_if_beq     = 1'b1;
                        w_pc_write   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    C_JR: begin
                        w_if_jr      = 1'b1;
                        w_pc_write   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    C_JAL: begin
                        w_if_jal     = 1'b1;
                        w_reg_write  = 1'b1;
                        w_pc_write   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    C_LW, C_SW: begin
                        w_next_state = S_MEM;
                    end
                    C_ADDU, C_SUBU, C_ORI, C_LUI: begin
                        w_next_state = S_WB;
                    end
                    default: begin
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                w_alu_op  = w_ex_alu_op;
                w_alu_src = w_ex_alu_src;
                w_ext_op  = w_ex_ext_op;
                case (w_class)
                    C_SW: begin
                        // Store is held until memory acknowledges, then retires.
                        w_mem_write = 1'b1;
                        if (dm_ready) begin
                            w_pc_write   = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_MEM;
                        end
                    end
                    C_LW: begin
                        if (dm_ready) begin
                            w_next_state = S_WB;
                        end else begin
                            w_next_state = S_MEM;
                        end
                    end
                    default: begin
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_WB: begin
                w_alu_op     = w_ex_alu_op;
                w_alu_src    = w_ex_alu_src;
                w_ext_op     = w_ex_ext_op;
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_reg_dst    = (w_class == C_ADDU) || (w_class == C_SUBU);
                w_mem_to_reg = (w_class == C_LW);
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Force every control low while reset is asserted, independent of the clock.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        EXTOp    = 2'b00;
        ALUOp    = 3'b000;
        if_beq   = 1'b0;
        if_jal   = 1'b0;
        if_jr    = 1'b0;
        if (reset) begin
            PCWrite  = w_pc_write;
            IRWrite  = w_ir_write;
            RegDst   = w_reg_dst;
            RegWrite = w_reg_write;
            ALUSrc   = w_alu_src;
            MemWrite = w_mem_write;
            MemToReg = w_mem_to_reg;
            EXTOp    = w_ext_op;
            ALUOp    = w_alu_op;
            if_beq   = w_if_beq;
            if_jal   = w_if_jal;
            if_jr    = w_if_jr;
        end else begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    // State register; reset aborts any in-flight instruction back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, one step per PC update, wrapping naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (PCWrite) begin
            r_count <= r_count + COUNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed plus randomized instruction streams for mc_ctrl,
// checked cycle by cycle against a per-instruction expected-trace model.

module tb_mc_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   Instr = 32'd0;
    logic          dm_ready = 1'b0;
    logic          PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, MemWrite, MemToReg;
    logic [1:0]    EXTOp;
    logic [2:0]    ALUOp;
    logic          if_beq, if_jal, if_jr;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    mc_ctrl #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .dm_ready(dm_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemToReg(MemToReg), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .if_beq(if_beq), .if_jal(if_jal), .if_jr(if_jr),
        .state(state), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, rdst, rw, asrc, mw, m2r;
        logic [1:0] ext;
        logic [2:0] alu;
        logic       beq, jal, jr;
    } ctl_t;

    ctl_t obs;
    assign obs = {state, PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, MemWrite,
                  MemToReg, EXTOp, ALUOp, if_beq, if_jal, if_jr};

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt    = 0;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4;
    localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_JAL = 8, K_NOP = 9;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h21:   return K_ADDU;
                    6'h23:   return K_SUBU;
                    6'h08:   return K_JR;
                    default: return K_NOP;
                endcase
            end
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h03:   return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [31:0] w;
        int k;
        r = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            K_ADDU:  w = {6'h00, r[25:6], 6'h21};
            K_SUBU:  w = {6'h00, r[25:6], 6'h23};
            K_JR:    w = {6'h00, r[25:6], 6'h08};
            K_ORI:   w = {6'h0D, r[25:0]};
            K_LUI:   w = {6'h0F, r[25:0]};
            K_LW:    w = {6'h23, r[25:0]};
            K_SW:    w = {6'h2B, r[25:0]};
            K_BEQ:   w = {6'h04, r[25:0]};
            K_JAL:   w = {6'h03, r[25:0]};
            default: begin
                w = r;
                if (r[0]) w[31:26] = 6'h00;
                while (classify(w) != K_NOP) begin
                    w = $urandom();
                end
            end
        endcase
        return w;
    endfunction

    // Build the expected per-cycle trace of one instruction and run it.
    // waits = MEM cycles with dm_ready low; abort_at = trace index at which
    // reset is pulsed (-1 for none).
    task automatic run_instr(input logic [31:0] w, input int waits, input int abort_at);
        ctl_t exp_q[$];
        logic dm_q[$];
        ctl_t e, x, z;
        int   k;
        k = classify(w);
        z = '0;
        e = z; e.irw = 1'b1;
        exp_q.push_back(e); dm_q.push_back(1'($urandom_range(0, 1)));
        e = z; e.st = 3'd1; e.pcw = (k == K_NOP);
        exp_q.push_back(e); dm_q.push_back(1'($urandom_range(0, 1)));
        if (k != K_NOP) begin
            x = z;
            case (k)
                K_SUBU:     x.alu = 3'd1;
                K_ORI:      begin x.alu = 3'd2; x.asrc = 1'b1; end
                K_LUI:      begin x.asrc = 1'b1; x.ext = 2'd2; end
                K_LW, K_SW: begin x.asrc = 1'b1; x.ext = 2'd1; end
                K_BEQ:      begin x.alu = 3'd1; x.ext = 2'd1; end
                default:    x = z;
            endcase
            e = x; e.st = 3'd2;
            if (k == K_BEQ) begin e.beq = 1'b1; e.pcw = 1'b1; end
            if (k == K_JR)  begin e.jr = 1'b1;  e.pcw = 1'b1; end
            if (k == K_JAL) begin e.jal = 1'b1; e.rw = 1'b1; e.pcw = 1'b1; end
            exp_q.push_back(e); dm_q.push_back(1'($urandom_range(0, 1)));
            if (k == K_LW || k == K_SW) begin
                for (int c = 0; c <= waits; c++) begin
                    e = x; e.st = 3'd3;
                    if (k == K_SW) begin e.mw = 1'b1; e.pcw = (c == waits); end
                    exp_q.push_back(e); dm_q.push_back(c == waits);
                end
            end
            if (k == K_LW || k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI) begin
                e = x; e.st = 3'd4; e.rw = 1'b1; e.pcw = 1'b1;
                e.rdst = (k == K_ADDU || k == K_SUBU);
                e.m2r  = (k == K_LW);
                exp_q.push_back(e); dm_q.push_back(1'($urandom_range(0, 1)));
            end
        end
        Instr = w;
        for (int i = 0; i < exp_q.size(); i++) begin
            dm_ready = dm_q[i];
            #1;
            if (i == 0) check_eq("count", 32'(instr_count), 32'(m_cnt));
            check_eq($sformatf("ctl[%08h#%0d]", w, i), 32'(obs), 32'(exp_q[i]));
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check_eq("abort_ctl", 32'(obs), 32'd0);
                check_eq("abort_cnt", 32'(instr_count), 32'd0);
                @(negedge clk);
                #1;
                check_eq("abort_hold", 32'(obs), 32'd0);
                m_cnt = 0;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
        end
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int ab;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_ctl", 32'(obs), 32'd0);
            check_eq("rst_cnt", 32'(instr_count), 32'd0);
        end
        reset = 1'b1;
        run_instr(32'h00221821, 0, -1);   // addu
        run_instr(32'h8C230004, 3, -1);   // lw, 3 wait cycles
        run_instr(32'hAC230004, 0, -1);   // sw, ready on entry
        run_instr(32'h0C000010, 0, -1);   // jal
        run_instr(32'h03E00008, 0, -1);   // jr $31
        run_instr(32'hFC000000, 0, -1);   // undefined -> NOP
        run_instr(32'h8C230004, 5, 4);    // lw, reset during MEM wait
        for (int n = 0; n < 250; n++) begin
            w  = gen_instr();
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(w, int'($urandom_range(0, 3)), ab);
        end
        dm_ready = 1'b0;
        #1;
        check_eq("count_final", 32'(instr_count), 32'(m_cnt));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
